// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the 512-point FFT
// butterfly scheduler.
package fft_pkg;
  localparam int N_LOG2 = 9;
  localparam int N_HALF = 1 << (N_LOG2 - 1);
  localparam int ADDR_W = N_LOG2;
  localparam int TW_W   = N_LOG2 - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;
endpackage

// File: rtl/fft512_addr_gen.sv
// Maps (stage, butterfly index) to the in-place DIT leg
// addresses and the twiddle ROM index.
module fft512_addr_gen #(
  parameter int N_LOG2 = 9
) (
  input  logic [3:0]        stage,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw
);
  localparam int AW = N_LOG2;
  localparam int TW = N_LOG2 - 1;

  logic [AW-1:0] kx;
  logic [AW-1:0] half;
  logic [AW-1:0] mask;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp;
  logic [TW-1:0] ptw;

  always_comb begin
    kx     = {1'b0, k};
    half   = {{(AW-1){1'b0}}, 1'b1} << stage;
    mask   = half - 1'b1;
    pos    = kx & mask;
    grp    = kx >> stage;
    // leg a has bit s clear, so b is a with that bit set
    addr_a = (grp << (stage + 4'd1)) | pos;
    addr_b = addr_a | half;
    ptw    = k & mask[TW-1:0];
    tw     = ptw << (TW - int'(stage));
  end
endmodule

// File: rtl/fft512_bfly_sched.sv
// Walks stages x butterflies of an in-place radix-2 DIT FFT,
// issuing reads each cycle and delayed write-backs.
module fft512_bfly_sched #(
  parameter int N_LOG2   = 9,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);
  import fft_pkg::*;

  localparam int AW = N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam int EW = 1 + 2 * AW;
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [3:0]    S_LAST = 4'(N_LOG2 - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  state_e        st_q, st_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    stg_q, stg_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [EW-1:0] dly_q [PIPE_LAT];
  logic [EW-1:0] dly_d [PIPE_LAT];

  logic          run;
  logic          issue;
  logic [AW-1:0] ag_a;
  logic [AW-1:0] ag_b;
  logic [KW-1:0] ag_tw;

  fft512_addr_gen #(.N_LOG2(N_LOG2)) u_ag (
    .stage  (stg_q),
    .k      (k_q),
    .addr_a (ag_a),
    .addr_b (ag_b),
    .tw     (ag_tw)
  );

  assign run   = (st_q == S_RUN);
  assign issue = run && !hold;

  always_comb begin
    st_d  = st_q;
    k_d   = k_q;
    stg_d = stg_q;
    drn_d = drn_q;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d  = S_RUN;
          k_d   = '0;
          stg_d = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            st_d  = S_DRAIN;
            drn_d = '0;
          end
        end
      end
      S_DRAIN: begin
        // wait out the pipeline so the next stage reads fresh data
        if (drn_q == D_LAST) begin
          if (stg_q == S_LAST) begin
            st_d = S_DONE;
          end else begin
            st_d  = S_RUN;
            stg_d = stg_q + 1'b1;
          end
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      S_DONE: begin
        st_d  = S_IDLE;
        stg_d = '0;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    dly_d[0] = {issue, rd_addr_a, rd_addr_b};
    for (int i = 1; i < PIPE_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_IDLE;
      k_q   <= '0;
      stg_q <= '0;
      drn_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      st_q  <= st_d;
      k_q   <= k_d;
      stg_q <= stg_d;
      drn_q <= drn_d;
      dly_q <= dly_d;
    end
  end

  assign busy      = (st_q != S_IDLE);
  assign done      = (st_q == S_DONE);
  assign stage     = stg_q;
  assign rd_en     = issue;
  assign rd_addr_a = run ? ag_a : '0;
  assign rd_addr_b = run ? ag_b : '0;
  assign tw_addr   = run ? ag_tw : '0;
  assign {wr_en, wr_addr_a, wr_addr_b} = dly_q[PIPE_LAT-1];
endmodule
